uart_rxd_frame_ctrl: RTL

Receive-side framing controller, the counterpart of the UART transmit framing controller. It consumes bytes from the UART byte receiver and locates the frame header {8'h01, 8'hFE}. It then assembles IMAGE_SIZE 16-bit words (low byte first), pushes each word into the downstream write FIFO, and checks the trailer {8'hFE, 8'h01}. It sits between the UART RX byte engine and the SDRAM write-side FIFO.

---
 rtl/uart_rxd_frame_ctrl.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/uart_rxd_frame_ctrl.sv
// Receive framing controller: finds the {MODE,~MODE} header, packs IMAGE_SIZE
// little-endian 16-bit words into the write FIFO, then checks the {~MODE,MODE} trailer.
module uart_rxd_frame_ctrl #(
  parameter int unsigned IMAGE_SIZE     = 16,
  parameter logic [7:0]  UART_SEND_MODE = 8'h01,
  parameter int unsigned TIMEOUT_CYC    = 500000
) (
  input  logic        SYS_CLK,
  input  logic        RST_N,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  input  logic        wr_fifo_full,
  output logic        wr_req,
  output logic [15:0] wr_data,
  output logic        in_frame,
  output logic        frame_done,
  output logic        frame_err
);

  localparam logic [7:0]  MODE_B    = UART_SEND_MODE;
  localparam logic [7:0]  MODE_N    = ~UART_SEND_MODE;
  localparam logic [17:0] WORD_LAST = 18'(IMAGE_SIZE);
  localparam logic [23:0] GAP_LAST  = 24'(TIMEOUT_CYC - 1);

  typedef enum logic [2:0] {
    S_H0, S_H1, S_LOW, S_HIGH, S_T0, S_T1
  } state_t;

  state_t      state_q, state_d;
  logic [17:0] word_cnt_q, word_cnt_d;
  logic [23:0] gap_q, gap_d;
  logic        drop_q, drop_d;
  logic [7:0]  low_q, low_d;
  logic        wr_req_q, wr_req_d;
  logic [15:0] wr_data_q, wr_data_d;
  logic        in_frame_q, in_frame_d;
  logic        frame_done_q, frame_done_d;
  logic        frame_err_q, frame_err_d;

  logic        timed;
  logic [17:0] word_cnt_inc;

  always_comb begin
    state_d      = state_q;
    word_cnt_d   = word_cnt_q;
    gap_d        = gap_q;
    drop_d       = drop_q;
    low_d        = low_q;
    wr_req_d     = 1'b0;
    wr_data_d    = wr_data_q;
    in_frame_d   = in_frame_q;
    frame_done_d = 1'b0;
    frame_err_d  = 1'b0;
    word_cnt_inc = word_cnt_q + 18'd1;
    timed        = (state_q == S_LOW) || (state_q == S_HIGH) ||
                   (state_q == S_T0)  || (state_q == S_T1);

    // The gap counter only runs while a frame is open and restarts on every byte.
    if (!timed || rx_valid) gap_d = '0;
    else                    gap_d = gap_q + 24'd1;

    if (timed && !rx_valid && (gap_q == GAP_LAST)) begin
      frame_err_d = 1'b1;
      in_frame_d  = 1'b0;
      state_d     = S_H0;
      gap_d       = '0;
    end else if (rx_valid) begin
      case (state_q)
        S_H0: begin
          if (rx_data == MODE_B) state_d = S_H1;
        end
        S_H1: begin
          if (rx_data == MODE_N) begin
            state_d    = S_LOW;
            word_cnt_d = '0;
            drop_d     = 1'b0;
            in_frame_d = 1'b1;
          end else if (rx_data != MODE_B) begin
            state_d = S_H0;
          end
        end
        S_LOW: begin
          low_d   = rx_data;
          state_d = S_HIGH;
        end
        S_HIGH: begin
          // A word that meets a full FIFO is lost but still counted, so the
          // trailer position stays where the sender put it.
          if (!wr_fifo_full) begin
            wr_req_d  = 1'b1;
            wr_data_d = {rx_data, low_q};
          end else begin
            drop_d = 1'b1;
          end
          word_cnt_d = word_cnt_inc;
          state_d    = (word_cnt_inc == WORD_LAST) ? S_T0 : S_LOW;
        end
        S_T0: begin
          if (rx_data == MODE_N) begin
            state_d = S_T1;
          end else begin
            frame_err_d = 1'b1;
            in_frame_d  = 1'b0;
            state_d     = S_H0;
          end
        end
        S_T1: begin
          if ((rx_data == MODE_B) && !drop_q) frame_done_d = 1'b1;
          else                                frame_err_d  = 1'b1;
          in_frame_d = 1'b0;
          state_d    = S_H0;
        end
        default: state_d = S_H0;
      endcase
    end
  end

  always_ff @(posedge SYS_CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q      <= S_H0;
      word_cnt_q   <= '0;
      gap_q        <= '0;
      drop_q       <= 1'b0;
      low_q        <= '0;
      wr_req_q     <= 1'b0;
      wr_data_q    <= '0;
      in_frame_q   <= 1'b0;
      frame_done_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      word_cnt_q   <= word_cnt_d;
      gap_q        <= gap_d;
      drop_q       <= drop_d;
      low_q        <= low_d;
      wr_req_q     <= wr_req_d;
      wr_data_q    <= wr_data_d;
      in_frame_q   <= in_frame_d;
      frame_done_q <= frame_done_d;
      frame_err_q  <= frame_err_d;
    end
  end

  assign wr_req     = wr_req_q;
  assign wr_data    = wr_data_q;
  assign in_frame   = in_frame_q;
  assign frame_done = frame_done_q;
  assign frame_err  = frame_err_q;

endmodule
